// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter.
//   N_REQ   : number of requesters
//   IDX_W   : width of a requester index
//   state_e : arbiter FSM state (idle / grant held)
package rr_arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arb_4to2_pick.sv
// Combinational rotate-priority picker.
// Scans req_i starting at ptr_i and wrapping modulo N_REQ; reports the first set bit.
//   req_i     : request vector
//   ptr_i     : channel with highest priority this round
//   any_o     : at least one request is set
//   win_idx_o : index of the winning channel (0 when any_o is low)
module rr_pick
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             any_o,
    output logic [IDX_W-1:0] win_idx_o
);

    logic [IDX_W-1:0] idx;

    // Walk from the farthest offset down to ptr_i so the nearest hit overwrites the rest.
    always_comb begin
        any_o     = 1'b0;
        win_idx_o = '0;
        idx       = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr_i + IDX_W'(i);
            if (req_i[idx]) begin
                any_o     = 1'b1;
                win_idx_o = idx;
            end
        end
    end

endmodule

// File: rtl/rr_arb_4to2.sv
// Four-requester round-robin arbiter with registered grant index, valid flag and
// hold-timer timeout pulse. gnt_idx_o feeds a 2-to-4 decoder to form the one-hot grant.
// A grant is held until done_i, the owner's request drops, or HOLD_MAX cycles elapse.
// After a release the next search starts at the channel after the last winner.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   req_i     : level-sensitive requests
//   done_i    : one-cycle release pulse from the current owner
//   lock_i    : (RR_ARB_LOCK_EN only) while high, only done_i can release a grant
//   gnt_idx_o : registered grant index, changes only on a grant edge
//   gnt_vld_o : registered, high while gnt_idx_o is a live grant
//   timeout_o : registered one-cycle pulse on a timer-only forced release
// Optional feature macro: RR_ARB_LOCK_EN.
module rr_arb_4to2
    import rr_arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 15,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_i,
    input  logic             done_i,
`ifdef RR_ARB_LOCK_EN
    input  logic             lock_i,
`endif
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_vld_o,
    output logic             timeout_o
);

    localparam logic [CNT_W-1:0] HoldMaxC = CNT_W'(HOLD_MAX);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_vld_q, gnt_vld_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             any;
    logic [IDX_W-1:0] win_idx;
    logic             lock;
    logic             rel_drop, rel_tmr, release_now;

    rr_pick u_pick (
        .req_i     (req_i),
        .ptr_i     (ptr_q),
        .any_o     (any),
        .win_idx_o (win_idx)
    );

`ifdef RR_ARB_LOCK_EN
    assign lock = lock_i;
`else
    assign lock = 1'b0;
`endif

    // Release causes; lock masks everything except done.
    assign rel_drop    = ~req_i[gnt_idx_q] & ~lock;
    assign rel_tmr     = (cnt_q == HoldMaxC) & ~lock;
    assign release_now = done_i | rel_drop | rel_tmr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            gnt_vld_q <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        gnt_vld_d = gnt_vld_q;
        timeout_d = 1'b0;
        cnt_d     = cnt_q;
        unique case (state_q)
            StIdle: begin
                gnt_vld_d = 1'b0;
                if (any) begin
                    state_d   = StGrant;
                    gnt_idx_d = win_idx;
                    gnt_vld_d = 1'b1;
                    cnt_d     = CNT_W'(1);
                end
            end
            StGrant: begin
                if (release_now) begin
                    state_d   = StIdle;
                    gnt_vld_d = 1'b0;
                    ptr_d     = gnt_idx_q + IDX_W'(1);
                    cnt_d     = '0;
                    // Only a pure timer expiry is reported; done or drop make it a normal release.
                    timeout_d = rel_tmr & ~done_i & ~rel_drop;
                end else if (cnt_q != HoldMaxC) begin
                    // Saturates at HOLD_MAX, which can only be reached here while locked.
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        gnt_idx_o = gnt_idx_q;
        gnt_vld_o = gnt_vld_q;
        timeout_o = timeout_q;
    end

endmodule

// File: tb/tb_rr_arb_4to2.sv
module tb_rr_arb_4to2;

    localparam int HOLD = 15;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic       lock;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: owner is -1 when no grant is live.
    int m_owner;
    int m_last;
    int m_ptr;
    int m_age;
    bit m_to;

    rr_arb_4to2 #(
        .HOLD_MAX (HOLD),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req),
        .done_i    (done),
`ifdef RR_ARB_LOCK_EN
        .lock_i    (lock),
`endif
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld),
        .timeout_o (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_last  = 0;
        m_ptr   = 0;
        m_age   = 0;
        m_to    = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic d, input logic l);
        bit lk;
        bit drop;
        bit expd;
        int c;
`ifdef RR_ARB_LOCK_EN
        lk = l;
`else
        lk = 1'b0;
`endif
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                c = (m_ptr + k) % 4;
                if (r[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_age   = 1;
                    break;
                end
            end
        end else begin
            drop = !r[m_owner] && !lk;
            expd = (m_age >= HOLD) && !lk;
            if (d || drop || expd) begin
                m_to    = expd && !d && !drop;
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_age   = 0;
            end else if (m_age < HOLD) begin
                m_age = m_age + 1;
            end
        end
    endtask

    // One clock edge; the model consumes the same inputs the DUT sampled.
    task automatic tick();
        @(posedge clk);
        model_step(req, done, lock);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        lock  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        lock  = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({gnt_vld, gnt_idx, timeout} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_state: got vld/idx/to=%b required 0000", {gnt_vld, gnt_idx, timeout});
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            got = {gnt_vld, gnt_idx, timeout};
            n_cmp++;
            if (got !== 4'b0000) begin
                n_err++;
                $display("FAIL idle_no_req cycle %0d: got %b required 0000", i, got);
            end
        end
    endtask

    task automatic test_rotation();
        logic [3:0] onehot;
        logic [3:0] exp_onehot;
        int         g_idx;
        do_reset();
        req = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            g_idx      = g % 4;
            exp_onehot = 4'b0001 << g_idx;
            onehot     = 4'b0001 << gnt_idx;
            n_cmp++;
            if (gnt_vld !== 1'b1 || gnt_idx !== 2'(g_idx) || onehot !== exp_onehot) begin
                n_err++;
                $display("FAIL rotation grant %0d: got vld=%b idx=%0d dec=%b required vld=1 idx=%0d dec=%b",
                         g, gnt_vld, gnt_idx, onehot, g_idx, exp_onehot);
            end
            tick();
            done = 1'b1;
            tick();
            done = 1'b0;
            n_cmp++;
            if (gnt_vld !== 1'b0 || timeout !== 1'b0) begin
                n_err++;
                $display("FAIL rotation gap %0d: got vld=%b to=%b required vld=0 to=0",
                         g, gnt_vld, timeout);
            end
            tick();
        end
        req = 4'b0000;
    endtask

    task automatic test_timeout();
        int vld_cycles;
        do_reset();
        req = 4'b0100;
        tick();
        vld_cycles = 0;
        while (gnt_vld === 1'b1 && vld_cycles < 40) begin
            vld_cycles++;
            n_cmp++;
            if (gnt_idx !== 2'd2 || timeout !== 1'b0) begin
                n_err++;
                $display("FAIL hold_stable cycle %0d: got idx=%0d to=%b required idx=2 to=0",
                         vld_cycles, gnt_idx, timeout);
            end
            tick();
        end
        n_cmp++;
        if (vld_cycles != HOLD || timeout !== 1'b1) begin
            n_err++;
            $display("FAIL hold_timeout: got %0d grant cycles to=%b required %0d cycles to=1",
                     vld_cycles, timeout, HOLD);
        end
        tick();
        n_cmp++;
        if (gnt_vld !== 1'b1 || gnt_idx !== 2'd2 || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_regrant: got vld=%b idx=%0d to=%b required vld=1 idx=2 to=0",
                     gnt_vld, gnt_idx, timeout);
        end
        req = 4'b0000;
    endtask

    task automatic test_req_drop();
        do_reset();
        req = 4'b0010;
        tick();
        n_cmp++;
        if (gnt_vld !== 1'b1 || gnt_idx !== 2'd1) begin
            n_err++;
            $display("FAIL drop_grant1: got vld=%b idx=%0d required vld=1 idx=1", gnt_vld, gnt_idx);
        end
        tick();
        req = 4'b1001;
        tick();
        n_cmp++;
        if (gnt_vld !== 1'b0 || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL drop_release: got vld=%b to=%b required vld=0 to=0", gnt_vld, timeout);
        end
        tick();
        n_cmp++;
        if (gnt_vld !== 1'b1 || gnt_idx !== 2'd3) begin
            n_err++;
            $display("FAIL drop_next: got vld=%b idx=%0d required vld=1 idx=3", gnt_vld, gnt_idx);
        end
        req = 4'b0000;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0100;
        tick();
        tick();
        n_cmp++;
        if (gnt_vld !== 1'b1 || gnt_idx !== 2'd2) begin
            n_err++;
            $display("FAIL areset_pre: got vld=%b idx=%0d required vld=1 idx=2", gnt_vld, gnt_idx);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({gnt_vld, gnt_idx, timeout} !== 4'b0000) begin
            n_err++;
            $display("FAIL areset_async: got vld/idx/to=%b required 0000", {gnt_vld, gnt_idx, timeout});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (gnt_vld !== 1'b1 || gnt_idx !== 2'd2) begin
            n_err++;
            $display("FAIL areset_regrant: got vld=%b idx=%0d required vld=1 idx=2", gnt_vld, gnt_idx);
        end
        req = 4'b0000;
    endtask

`ifdef RR_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        lock = 1'b1;
        req  = 4'b0001;
        tick();
        req = 4'b0000;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_cmp++;
            if (gnt_vld !== 1'b1 || gnt_idx !== 2'd0 || timeout !== 1'b0) begin
                n_err++;
                $display("FAIL lock_hold cycle %0d: got vld=%b idx=%0d to=%b required vld=1 idx=0 to=0",
                         i, gnt_vld, gnt_idx, timeout);
            end
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        lock = 1'b0;
        n_cmp++;
        if (gnt_vld !== 1'b0 || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL lock_done: got vld=%b to=%b required vld=0 to=0", gnt_vld, timeout);
        end
    endtask
`endif

    task automatic test_random();
        logic [3:0] exp;
        logic [3:0] got;
        int         errs_here;
        do_reset();
        errs_here = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) req = 4'($urandom);
            done = ($urandom_range(7) == 0);
`ifdef RR_ARB_LOCK_EN
            if ($urandom_range(15) == 0) lock = ~lock;
`endif
            tick();
            exp = {(m_owner >= 0), 2'(m_last), m_to};
            got = {gnt_vld, gnt_idx, timeout};
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                errs_here++;
                if (errs_here <= 10)
                    $display("FAIL random cycle %0d: got vld/idx/to=%b required %b", i, got, exp);
            end
        end
        req  = 4'b0000;
        done = 1'b0;
        lock = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        lock  = 1'b0;
        model_reset();
        test_reset();
        test_rotation();
        test_timeout();
        test_req_drop();
        test_async_reset();
`ifdef RR_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
